// File: rtl/perf_cnt_ctrl.sv
// Performance-counter controller: cycle/instruction measurement windows driven by ID-stage decoder signals.
// Optional feature macro PERF_SAT_EN: counters saturate at max instead of wrapping.
module perf_cnt_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             str_ccnt,
    input  logic             str_icnt,
    input  logic             stp_cnt,
    input  logic             inc_instr,
    input  logic             clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cycle_cnt,
    output logic [WIDTH-1:0] instr_cnt,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, CCNT, ICNT, DONE} state_t;

    state_t           state;
    logic             stp;
    logic             start_c;
    logic             start_i;
    logic             inc;
    logic             cycle_hit;
    logic             instr_hit;
    logic [WIDTH-1:0] cycle_next;
    logic [WIDTH-1:0] instr_next;

    // Commands only count for real ID slots; stop outranks cycle start, which outranks instr start.
    assign stp     = id_valid & stp_cnt;
    assign start_c = id_valid & str_ccnt & ~stp_cnt;
    assign start_i = id_valid & str_icnt & ~stp_cnt & ~str_ccnt;
    assign inc     = id_valid & inc_instr;

    assign cycle_hit = &cycle_cnt;
    assign instr_hit = &instr_cnt;

`ifdef PERF_SAT_EN
    assign cycle_next = cycle_hit ? cycle_cnt : cycle_cnt + WIDTH'(1);
    assign instr_next = instr_hit ? instr_cnt : instr_cnt + WIDTH'(1);
`else
    assign cycle_next = cycle_cnt + WIDTH'(1);
    assign instr_next = instr_cnt + WIDTH'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start_c) begin
                        state     <= CCNT;
                        busy      <= 1'b1;
                        cycle_cnt <= '0;
                    end else if (start_i) begin
                        state     <= ICNT;
                        busy      <= 1'b1;
                        instr_cnt <= '0;
                    end
                end
                CCNT: begin
                    // The cycle counter advances on every edge spent in CCNT, even the leaving one.
                    if (start_c) begin
                        cycle_cnt <= '0;
                    end else begin
                        cycle_cnt <= cycle_next;
                        if (cycle_hit) ovf <= 1'b1;
                    end
                    if (stp) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (start_i) begin
                        state     <= ICNT;
                        instr_cnt <= '0;
                    end
                end
                ICNT: begin
                    if (start_i) begin
                        instr_cnt <= WIDTH'(inc);
                    end else if (inc) begin
                        instr_cnt <= instr_next;
                        if (instr_hit) ovf <= 1'b1;
                    end
                    if (stp) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (start_c) begin
                        state     <= CCNT;
                        cycle_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Clear wins over any counter update on the same edge; the state move still happens.
            if (clr) begin
                cycle_cnt <= '0;
                instr_cnt <= '0;
                ovf       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_perf_cnt_ctrl.sv
// Self-checking bench for perf_cnt_ctrl (WIDTH=4) against a window-level reference model.
// Honours PERF_SAT_EN the same way as the design when it is defined.
module tb_perf_cnt_ctrl;

    localparam int W = 4;
    localparam longint MAXV = (64'd1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         id_valid = 1'b0;
    logic         str_ccnt = 1'b0;
    logic         str_icnt = 1'b0;
    logic         stp_cnt = 1'b0;
    logic         inc_instr = 1'b0;
    logic         clr = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] cycle_cnt;
    logic [W-1:0] instr_cnt;
    logic         ovf;

    int checks = 0;
    int failures = 0;

    // Reference model: which window is open plus raw (unbounded) event counts since last zeroing.
    typedef enum {M_NONE, M_CYC, M_INS, M_FIN} mode_t;
    mode_t  mMode = M_NONE;
    longint cRaw = 0;
    longint iRaw = 0;
    bit     mOvf = 1'b0;
    bit     mDone = 1'b0;

    perf_cnt_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .str_ccnt(str_ccnt),
        .str_icnt(str_icnt), .stp_cnt(stp_cnt), .inc_instr(inc_instr), .clr(clr),
        .busy(busy), .done(done), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic longint shown(input longint raw);
`ifdef PERF_SAT_EN
        return (raw > MAXV) ? MAXV : raw;
`else
        return raw % (MAXV + 1);
`endif
    endfunction

    // An increment attempted while the visible value is at max overflows in both builds.
    function automatic bit hitsMax(input longint raw);
        return shown(raw) == MAXV;
    endfunction

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".busy"}, longint'(busy), longint'(mMode == M_CYC || mMode == M_INS));
        checkOutput({tag, ".done"}, longint'(done), longint'(mDone));
        checkOutput({tag, ".cycle_cnt"}, longint'(cycle_cnt), shown(cRaw));
        checkOutput({tag, ".instr_cnt"}, longint'(instr_cnt), shown(iRaw));
        checkOutput({tag, ".ovf"}, longint'(ovf), longint'(mOvf));
    endtask

    task automatic modelStep(input bit v, input bit sc, input bit si, input bit sp,
                             input bit inc, input bit c);
        bit doStop;
        bit doCyc;
        bit doIns;
        bit doInc;
        doStop = v & sp;
        doCyc  = v & sc & ~sp;
        doIns  = v & si & ~sp & ~sc;
        doInc  = v & inc;
        mDone  = 1'b0;
        case (mMode)
            M_NONE, M_FIN: begin
                if (doCyc) begin mMode = M_CYC; cRaw = 0; end
                else if (doIns) begin mMode = M_INS; iRaw = 0; end
            end
            M_CYC: begin
                if (doCyc) cRaw = 0;
                else begin
                    if (hitsMax(cRaw)) mOvf = 1'b1;
                    cRaw++;
                end
                if (doStop) begin mMode = M_FIN; mDone = 1'b1; end
                else if (doIns) begin mMode = M_INS; iRaw = 0; end
            end
            M_INS: begin
                if (doIns) iRaw = doInc ? 1 : 0;
                else if (doInc) begin
                    if (hitsMax(iRaw)) mOvf = 1'b1;
                    iRaw++;
                end
                if (doStop) begin mMode = M_FIN; mDone = 1'b1; end
                else if (doCyc) begin mMode = M_CYC; cRaw = 0; end
            end
            default: ;
        endcase
        if (c) begin cRaw = 0; iRaw = 0; mOvf = 1'b0; end
    endtask

    task automatic applyStimulus(input bit v, input bit sc, input bit si, input bit sp,
                                 input bit inc, input bit c, input string tag);
        @(negedge clk);
        id_valid = v; str_ccnt = sc; str_icnt = si; stp_cnt = sp; inc_instr = inc; clr = c;
        @(posedge clk);
        modelStep(v, sc, si, sp, inc, c);
        #1;
        checkAll(tag);
    endtask

    task automatic modelReset();
        mMode = M_NONE; cRaw = 0; iRaw = 0; mOvf = 1'b0; mDone = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        id_valid = 0; str_ccnt = 0; str_icnt = 0; stp_cnt = 0; inc_instr = 0; clr = 0;
        rst = 1'b1;
        modelReset();
        #1;
        checkAll("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        doReset();

        // 10-cycle window: start at one edge, stop 10 edges later.
        applyStimulus(1, 1, 0, 0, 0, 0, "win_start");
        checkOutput("win_busy_on", longint'(busy), 1);
        repeat (9) applyStimulus(0, 0, 0, 0, 0, 0, "win_run");
        applyStimulus(1, 0, 0, 1, 0, 0, "win_stop");
        checkOutput("win_cycle_final", longint'(cycle_cnt), 10);
        checkOutput("win_done_pulse", longint'(done), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, "win_after");
        checkOutput("win_done_cleared", longint'(done), 0);

        // Instruction window with stalled copies that must not count.
        applyStimulus(1, 0, 1, 0, 0, 0, "ins_start");
        repeat (5) applyStimulus(1, 0, 0, 0, 1, 0, "ins_valid");
        repeat (3) applyStimulus(0, 0, 0, 1, 1, 0, "ins_stalled");
        applyStimulus(1, 0, 0, 1, 1, 0, "ins_stop");
        checkOutput("ins_final", longint'(instr_cnt), 6);

        // Stop while idle is ignored; stop beats start in the same slot.
        doReset();
        applyStimulus(1, 0, 0, 1, 0, 0, "idle_stop");
        checkOutput("idle_stop_done", longint'(done), 0);
        applyStimulus(1, 1, 0, 1, 0, 0, "idle_start_stop");
        checkOutput("idle_start_stop_busy", longint'(busy), 0);

        // Clear during an increment edge.
        applyStimulus(1, 1, 0, 0, 0, 0, "clr_start");
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, "clr_run");
        checkOutput("clr_pre", longint'(cycle_cnt), 4);
        applyStimulus(0, 0, 0, 0, 0, 1, "clr_edge");
        checkOutput("clr_zero", longint'(cycle_cnt), 0);
        checkOutput("clr_busy", longint'(busy), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, "clr_next");
        checkOutput("clr_next_one", longint'(cycle_cnt), 1);

        // 20-cycle window on a 4-bit counter.
        applyStimulus(1, 0, 0, 1, 0, 0, "ovf_stop_prev");
        applyStimulus(0, 0, 0, 0, 0, 1, "ovf_clear");
        applyStimulus(1, 1, 0, 0, 0, 0, "ovf_start");
        repeat (19) applyStimulus(0, 0, 0, 0, 0, 0, "ovf_run");
        applyStimulus(1, 0, 0, 1, 0, 0, "ovf_stop");
`ifdef PERF_SAT_EN
        checkOutput("ovf_cycle", longint'(cycle_cnt), 15);
`else
        checkOutput("ovf_cycle", longint'(cycle_cnt), 4);
`endif
        checkOutput("ovf_flag", longint'(ovf), 1);

        // Asynchronous reset in the middle of a cycle window.
        applyStimulus(1, 1, 0, 0, 0, 0, "rst_start");
        repeat (7) applyStimulus(0, 0, 0, 0, 0, 0, "rst_run");
        checkOutput("rst_pre", longint'(cycle_cnt), 7);
        @(negedge clk);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkAll("rst_async");
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom % 4) != 0, ($urandom % 12) == 0, ($urandom % 12) == 0,
                          ($urandom % 10) == 0, ($urandom % 2) == 1, ($urandom % 40) == 0,
                          "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/perf_cnt_ctrl.md
# perf_cnt_ctrl

Performance-counter controller driven by the decoder's special control signals in the ID stage. It sequences a cycle-count or instruction-count measurement window opened by `str_ccnt`/`str_icnt` and closed by `stp_cnt`. It counts clock cycles or retired-at-decode instructions (`inc_instr`) while the window is open, and holds the result for readout. It sits beside the ID stage and is qualified by the pipeline's ID valid signal, so stalled or flushed slots never start, stop or count.

## Interface
- `WIDTH`, default 32, counter width in bits.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID slot holds a real instruction this cycle (not bubble, not stalled, not flushed).
- `str_ccnt`  in  1  decoder: start cycle-count window.
- `str_icnt`  in  1  decoder: start instruction-count window.
- `stp_cnt`  in  1  decoder: stop current window.
- `inc_instr`  in  1  decoder: instruction counts toward instruction count.
- `clr`  in  1  synchronous clear of both counters and `ovf`.
- `busy`  out  1  window open (state CCNT or ICNT).
- `done`  out  1  one-cycle pulse on entry to DONE.
- `cycle_cnt`  out  WIDTH  cycle counter value.
- `instr_cnt`  out  WIDTH  instruction counter value.
- `ovf`  out  1  sticky overflow flag (see Configuration).

## Operation
- Decoder inputs are effective only when `id_valid`=1; otherwise ignored entirely.
- States: IDLE (reset), CCNT, ICNT, DONE. Encoding is free; `busy`/`done` are registered.
- Command priority in one cycle: `stp_cnt` > `str_ccnt` > `str_icnt`.
- IDLE or DONE: `str_ccnt` -> CCNT, `cycle_cnt` <= 0; `str_icnt` -> ICNT, `instr_cnt` <= 0; `stp_cnt` ignored (no state change, no `done`).
- CCNT: `cycle_cnt` += 1 on every edge, including the edge that leaves CCNT. `stp_cnt` -> DONE. `str_ccnt` restarts: `cycle_cnt` <= 0, stays CCNT. `str_icnt` switches to ICNT with `instr_cnt` <= 0; `cycle_cnt` freezes at its incremented value.
- ICNT: `instr_cnt` += 1 on edges where `inc_instr` & `id_valid`, including the stopping instruction when it asserts `inc_instr`. `stp_cnt` -> DONE. `str_icnt` restarts: `instr_cnt` <= 0 + (`inc_instr` ? 1 : 0). `str_ccnt` switches to CCNT with `cycle_cnt` <= 0.
- Counter not owned by the current state holds its value.
- DONE: both counters hold until a new start or `clr`.
- `clr` overrides any increment or start-clear on the same edge: both counters and `ovf` <= 0. The state transition still occurs.
- Arithmetic is unsigned modulo 2^WIDTH unless PERF_SAT_EN is defined.

## Timing
- All outputs are registered; reset values: state IDLE, `busy`=0, `done`=0, `cycle_cnt`=0, `instr_cnt`=0, `ovf`=0.
- Latency: a command sampled at edge N is visible at outputs after edge N; `done` is high for exactly the cycle following the stop edge.
- Cycle window: `str_ccnt` accepted at edge S, `stp_cnt` accepted at edge E gives final `cycle_cnt` = E - S.
- `rst` mid-window aborts immediately and forces all reset values asynchronously; no `done` pulse.
- A stall (`id_valid`=0) holding a `stp_cnt` instruction delays the stop; cycles keep counting meanwhile.

## Configuration
- `PERF_SAT_EN` defined: counters saturate at 2^WIDTH-1. An increment attempted at max sets `ovf`=1, which is sticky until `clr`/`rst`.
- Not defined: counters wrap to 0. `ovf` is set on wrap, also sticky.
- Start-clear and `clr` behaviour is identical in both builds.

## Test plan
- Reset mid-CCNT at `cycle_cnt`=7 -> all outputs 0, state IDLE immediately, no `done`.
- `str_ccnt` valid at edge 10, `stp_cnt` valid at edge 20 -> `cycle_cnt`=10, `done` high one cycle, `busy` 1 during edges 11..20 window then 0.
- `str_icnt`, then 5 valid `inc_instr` instructions plus 3 stalled copies (`id_valid`=0), then `stp_cnt` with `inc_instr`=1 -> `instr_cnt`=6.
- `stp_cnt` in IDLE -> no `done`, counters 0; `str_ccnt`+`stp_cnt` same valid cycle in IDLE -> stays IDLE.
- `clr` same cycle as CCNT increment at `cycle_cnt`=4 -> `cycle_cnt`=0, `busy` stays 1, next edge gives 1.
- WIDTH=4, cycle window of 20 cycles -> with PERF_SAT_EN `cycle_cnt`=15 and `ovf`=1; without it `cycle_cnt`=4 and `ovf`=1.
